// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: core-wide address width,
// PC increment and the per-update training action.
package branch_predictor_pkg;

  localparam int XLEN   = 32;
  localparam int PC_INC = 4;

  // What a resolved branch/jump does to its BTB entry.
  typedef enum logic [2:0] {
    TR_NONE,   // bubble, or not-taken miss
    TR_MAX,    // hit on a jump: force strongly taken
    TR_INC,    // hit, taken
    TR_DEC,    // hit, not taken
    TR_ALLOC   // taken miss: (re)allocate the entry
  } train_e;

  // Chooses the training action for one resolved instruction.
  function automatic train_e train_action(input logic upd, input logic hit,
                                          input logic is_jump, input logic taken);
    train_e act;
    act = TR_NONE;
    if (upd) begin
      if (hit) begin
        if (is_jump)    act = TR_MAX;
        else if (taken) act = TR_INC;
        else            act = TR_DEC;
      end else if (taken) begin
        act = TR_ALLOC;
      end
    end
    return act;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signals between the datapath and the branch predictor.
interface branch_predictor_if #(
  parameter int XLEN  = branch_predictor_pkg::XLEN,
  parameter int CNT_W = 32
);
  // F-stage lookup
  logic [XLEN-1:0]  PC_F;
  logic             Pred_Taken_F;
  logic [XLEN-1:0]  Pred_Next_F;
  // E-stage resolution and training
  logic             Update_EN_E;
  logic             Is_Jump_E;
  logic             Taken_E;
  logic [XLEN-1:0]  PC_E;
  logic [XLEN-1:0]  Target_E;
  logic             Pred_Taken_E;
  logic [XLEN-1:0]  Pred_Next_E;
  logic             Mispredict_E;
  logic [XLEN-1:0]  Redirect_PC_E;
  // Performance statistics
  logic             Clear_Stats;
  logic [CNT_W-1:0] Branch_Count;
  logic [CNT_W-1:0] Mispredict_Count;

  modport master (
    output PC_F, Update_EN_E, Is_Jump_E, Taken_E, PC_E, Target_E,
           Pred_Taken_E, Pred_Next_E, Clear_Stats,
    input  Pred_Taken_F, Pred_Next_F, Mispredict_E, Redirect_PC_E,
           Branch_Count, Mispredict_Count
  );

  modport slave (
    input  PC_F, Update_EN_E, Is_Jump_E, Taken_E, PC_E, Target_E,
           Pred_Taken_E, Pred_Next_E, Clear_Stats,
    output Pred_Taken_F, Pred_Next_F, Mispredict_E, Redirect_PC_E,
           Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with set-to-max and synchronous load.
// Priority: load > set_max > inc > dec.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         set_max,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  // Counter state; holds at all-ones on increment and at zero on decrement.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 q <= RST_VAL;
    else if (load)              q <= load_val;
    else if (set_max)           q <= '1;
    else if (inc && (q != '1))  q <= q + W'(1);
    else if (dec && (q != '0))  q <= q - W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// F-stage lookup is combinational; training and mispredict detection use
// the resolved branch in E. Also keeps saturating performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN     = branch_predictor_pkg::XLEN,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 2,
  parameter int CNT_W    = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(PC_INC);

  // BTB storage
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  // Index/tag split for both ports
  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  train_e           act_e;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_low;
  assign unused_pc_low = ^{bp.PC_F[1:0], bp.PC_E[1:0]};

  assign idx_f = bp.PC_F[IDX+1:2];
  assign tag_f = bp.PC_F[XLEN-1:IDX+2];
  assign idx_e = bp.PC_E[IDX+1:2];
  assign tag_e = bp.PC_E[XLEN-1:IDX+2];

  // F-stage lookup: reads pre-edge contents, so a same-cycle update to the
  // same index becomes visible only from the next cycle.
  assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign bp.Pred_Taken_F = hit_f && ctr_q[idx_f][CTR_BITS-1];
  assign bp.Pred_Next_F  = bp.Pred_Taken_F ? target_q[idx_f] : bp.PC_F + PC_STEP;

  // E-stage mispredict detection and redirect target.
  assign bp.Mispredict_E  = bp.Update_EN_E &&
                            ((bp.Taken_E != bp.Pred_Taken_E) ||
                             (bp.Taken_E && (bp.Target_E != bp.Pred_Next_E)));
  assign bp.Redirect_PC_E = bp.Taken_E ? bp.Target_E : bp.PC_E + PC_STEP;

  // Training decision for the entry selected by PC_E.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hit_e = 1'b0;
    hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    act_e = train_action(bp.Update_EN_E, hit_e, bp.Is_Jump_E, bp.Taken_E);
  end

  // Valid bits: cleared on reset, set on allocation, never cleared otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 valid_q        <= '0;
    else if (act_e == TR_ALLOC) valid_q[idx_e] <= 1'b1;
  end

  // Tag/target arrays: written on allocation and on taken hits.
  // NOTE: these arrays are deliberately not reset; valid gates every read,
  // and leaving them reset-free keeps them as plain storage.
  always_ff @(posedge clk) begin
    if (act_e == TR_ALLOC) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= bp.Target_E;
    end else if ((act_e == TR_MAX) || (act_e == TR_INC)) begin
      target_q[idx_e] <= bp.Target_E;
    end
  end

  // Per-entry direction counters.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (idx_e == IDX'(i));

    sat_counter #(.W(CTR_BITS), .RST_VAL(CTR_INIT)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (sel && (act_e == TR_ALLOC)),
      .load_val (bp.Is_Jump_E ? CTR_MAX : CTR_INIT),
      .set_max  (sel && (act_e == TR_MAX)),
      .inc      (sel && (act_e == TR_INC)),
      .dec      (sel && (act_e == TR_DEC)),
      .q        (ctr_q[i])
    );
  end

  // Performance counters; clear wins over increment.
  sat_counter #(.W(CNT_W), .RST_VAL('0)) u_branch_count (
    .clk      (clk),
    .reset    (reset),
    .load     (bp.Clear_Stats),
    .load_val ('0),
    .set_max  (1'b0),
    .inc      (bp.Update_EN_E),
    .dec      (1'b0),
    .q        (bp.Branch_Count)
  );

  sat_counter #(.W(CNT_W), .RST_VAL('0)) u_mispredict_count (
    .clk      (clk),
    .reset    (reset),
    .load     (bp.Clear_Stats),
    .load_val ('0),
    .set_max  (1'b0),
    .inc      (bp.Mispredict_E),
    .dec      (1'b0),
    .q        (bp.Mispredict_Count)
  );

endmodule
